data_mem_arbiter: RTL and testbench

- Round-robin arbiter sharing the single-port DATA_RAM (1-cycle write, registered-address read) between N_CORES processor cores.
- Sits between the core load/store ports and the RAM. It serialises accesses, drives the RAM address, write-enable and data, and returns read data with a per-core done pulse.
- One access completes per 3-cycle IDLE→ACCESS→RESP sequence.

---
 rtl/data_mem_arbiter.sv | 108 ++++++++++
 tb/tb_data_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that serialises core load/store requests onto a single-port
// data RAM; each access runs IDLE -> ACCESS -> RESP and ends with a per-core done pulse.
module data_mem_arbiter #(
    parameter int N_CORES    = 4,
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int IDX_W      = $clog2(N_CORES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CORES-1:0]            core_req,
    input  logic [N_CORES-1:0]            core_wrEn,
    input  logic [N_CORES*ADDR_WIDTH-1:0] core_addr,
    input  logic [N_CORES*WIDTH-1:0]      core_dataIn,
    output logic [N_CORES-1:0]            core_done,
    output logic [WIDTH-1:0]              core_dataOut,
    output logic                          busy,
    output logic                          ram_wrEn,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [WIDTH-1:0]              ram_dataIn,
    input  logic [WIDTH-1:0]              ram_dataOut
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  op_wr_q, op_wr_d;
    logic [IDX_W-1:0]      winner_s;
    logic                  found_s;
    logic [ADDR_WIDTH-1:0] addr_arr_s [N_CORES];
    logic [WIDTH-1:0]      data_arr_s [N_CORES];

    // Cyclic successor of the last winner; the only arithmetic in the block.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int offs);
        return IDX_W'((int'(base) + offs) % N_CORES);
    endfunction

    genvar k;
    generate
        for (k = 0; k < N_CORES; k++) begin : g_core
            assign addr_arr_s[k] = core_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_arr_s[k] = core_dataIn[k*WIDTH +: WIDTH];
            assign core_done[k]  = (state_q == S_RESP) && (sel_q == IDX_W'(k));
        end
    endgenerate

    // Round-robin search: first requester starting just after the previous winner.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int i = 1; i <= N_CORES; i++) begin
            winner_s = (!found_s && core_req[rr_idx(ptr_q, i)]) ? rr_idx(ptr_q, i) : winner_s;
            found_s  = found_s | core_req[rr_idx(ptr_q, i)];
        end
    end

    // Next-state logic; a grant is only taken in IDLE, so late requests wait a slot.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        op_wr_d = op_wr_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    sel_d   = winner_s;
                    ptr_d   = winner_s;
                    op_wr_d = core_wrEn[winner_s];
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register; ptr resets to the last core so core 0 is served first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            ptr_q   <= IDX_W'(N_CORES - 1);
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            op_wr_q <= op_wr_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign ram_wrEn     = (state_q == S_ACCESS) && op_wr_q;
    assign ram_addr     = addr_arr_s[sel_q];
    assign ram_dataIn   = data_arr_s[sel_q];
    assign core_dataOut = ram_dataOut;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: behavioural RAM, transaction-level
// round-robin reference model, directed test-plan scenarios and random traffic.
module tb_data_mem_arbiter;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int D  = 4096;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    core_req, core_wrEn, core_done;
    logic [N*AW-1:0] core_addr;
    logic [N*W-1:0]  core_dataIn;
    logic [W-1:0]    core_dataOut, ram_dataIn, ram_dataOut;
    logic            busy, ram_wrEn;
    logic [AW-1:0]   ram_addr;

    logic [AW-1:0]   a_v [N];
    logic [W-1:0]    d_v [N];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_pack
            assign core_addr[g*AW +: AW]  = a_v[g];
            assign core_dataIn[g*W +: W]  = d_v[g];
        end
    endgenerate

    data_mem_arbiter #(.N_CORES(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .core_req(core_req), .core_wrEn(core_wrEn),
        .core_addr(core_addr), .core_dataIn(core_dataIn), .core_done(core_done),
        .core_dataOut(core_dataOut), .busy(busy), .ram_wrEn(ram_wrEn),
        .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
    );

    // Single-port RAM: one-cycle write, registered read address
    logic [W-1:0]  mem [D];
    logic [AW-1:0] raddr_q;
    logic          fill_en;
    logic [AW-1:0] fill_addr;
    logic [W-1:0]  fill_data;
    always @(posedge clk) begin
        if (fill_en) mem[fill_addr] <= fill_data;
        else if (ram_wrEn) mem[ram_addr] <= ram_dataIn;
        raddr_q <= ram_addr;
    end
    assign ram_dataOut = mem[raddr_q];

    // Reference model state (transaction level)
    logic [W-1:0]  shadow [D];
    int            cyc, free_at, last, acc_cyc, cur;
    bit            acc_valid, cur_wr;
    logic [AW-1:0] cur_addr;
    logic [W-1:0]  cur_data, last_rd;
    bit            pend [N];
    bit            keep [N];
    int            done_q [$];
    int            done_t [$];
    int            wr_cnt, errors, checks;
    int            rq, n0, t0, t1, t2;
    logic [AW-1:0] ba [3];
    logic [W-1:0]  bd [3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic issue(input int k, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
        core_req[k]  = 1'b1;
        core_wrEn[k] = wr;
        a_v[k]       = a;
        d_v[k]       = d;
        pend[k]      = 1'b1;
    endtask

    // One cycle of checking at the falling edge, retiring a completed access.
    task automatic observe();
        logic [N-1:0] exp_done;
        bit in_acc, in_resp;
        @(negedge clk);
        cyc++;
        in_acc   = acc_valid && (cyc == acc_cyc + 1);
        in_resp  = acc_valid && (cyc == acc_cyc + 2);
        exp_done = in_resp ? (4'b0001 << cur) : 4'b0000;
        check_eq("core_done", 32'(core_done), 32'(exp_done));
        check_eq("busy", 32'(busy), 32'(in_acc || in_resp));
        check_eq("ram_wrEn", 32'(ram_wrEn), 32'(in_acc && cur_wr));
        if (ram_wrEn) wr_cnt++;
        for (int k = 0; k < N; k++) begin
            if (core_done[k]) begin
                done_q.push_back(k);
                done_t.push_back(cyc);
            end
        end
        if (in_resp) begin
            if (cur_wr) begin
                shadow[cur_addr] = cur_data;
            end else begin
                check_eq("rd_data", 32'(core_dataOut), 32'(shadow[cur_addr]));
                last_rd = core_dataOut;
            end
            acc_valid = 1'b0;
            if (!keep[cur]) begin
                pend[cur]     = 1'b0;
                core_req[cur] = 1'b0;
            end
        end
    endtask

    // Grant decision for requests visible in this cycle, if the RAM is free.
    task automatic decide();
        int c;
        if (cyc >= free_at && core_req != '0) begin
            for (int i = 1; i <= N; i++) begin
                c = (last + i) % N;
                if (core_req[c]) break;
            end
            acc_valid = 1'b1;
            acc_cyc   = cyc;
            cur       = c;
            cur_wr    = core_wrEn[c];
            cur_addr  = a_v[c];
            cur_data  = d_v[c];
            last      = c;
            free_at   = cyc + 3;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            observe();
            decide();
        end
    endtask

    task automatic wait_done(input int k, input int budget);
        for (int n = 0; n < budget; n++) begin
            observe();
            if (!pend[k]) break;
            decide();
        end
        check_eq("done_wait", 32'(pend[k]), 32'd0);
    endtask

    initial begin
        rst = 1'b1; core_req = '0; core_wrEn = '0; fill_en = 1'b0;
        fill_addr = '0; fill_data = '0; last_rd = '0;
        errors = 0; checks = 0; cyc = 0; free_at = 0; last = N - 1;
        acc_valid = 1'b0; cur = 0; cur_wr = 1'b0; wr_cnt = 0;
        for (int k = 0; k < N; k++) begin
            a_v[k] = '0; d_v[k] = '0; pend[k] = 1'b0; keep[k] = 1'b0;
        end
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            fill_en   = 1'b1;
            fill_addr = AW'(i);
            fill_data = W'($urandom);
            shadow[i] = fill_data;
        end
        @(negedge clk);
        fill_en = 1'b0;
        check_eq("rst_done", 32'(core_done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wrEn", 32'(ram_wrEn), 32'd0);
        rst = 1'b0;

        // All cores read at once straight after reset: order 0,1,2,3, 3 cycles apart
        for (int k = 0; k < N; k++) issue(k, 1'b0, AW'(32'h300 + k * 7), '0);
        decide();
        run(12);
        check_eq("cont_count", 32'(done_q.size()), 32'd4);
        for (int i = 0; i < done_q.size() && i < N; i++) begin
            check_eq("cont_order", 32'(done_q[i]), 32'(i));
            if (i > 0) check_eq("cont_gap", 32'(done_t[i] - done_t[i-1]), 32'd3);
        end

        // Core 2 writes then reads back
        observe();
        wr_cnt = 0;
        issue(2, 1'b1, 12'h010, 12'hA5C);
        decide();
        wait_done(2, 6);
        issue(2, 1'b0, 12'h010, 12'h000);
        decide();
        wait_done(2, 6);
        check_eq("wr_rd_data", 32'(last_rd), 32'h0A5C);
        check_eq("wr_pulse_cnt", 32'(wr_cnt), 32'd1);
        decide();

        // Core 1 back-to-back writes including the top address, then read back
        ba[0] = 12'h000; ba[1] = 12'h001; ba[2] = 12'hFFF;
        for (int i = 0; i < 3; i++) bd[i] = W'($urandom);
        observe();
        issue(1, 1'b1, ba[0], bd[0]); decide(); wait_done(1, 8); t0 = cyc;
        issue(1, 1'b1, ba[1], bd[1]); decide(); wait_done(1, 8); t1 = cyc;
        issue(1, 1'b1, ba[2], bd[2]); decide(); wait_done(1, 8); t2 = cyc;
        check_eq("b2b_gap1", 32'(t1 - t0), 32'd3);
        check_eq("b2b_gap2", 32'(t2 - t1), 32'd3);
        for (int i = 0; i < 3; i++) begin
            issue(1, 1'b0, ba[i], '0);
            decide();
            wait_done(1, 8);
            check_eq("b2b_rd", 32'(last_rd), 32'(bd[i]));
        end
        decide();

        // Core 2 drops req during ACCESS: the write still completes
        observe();
        issue(2, 1'b1, 12'h123, 12'h5E7);
        decide();
        observe();
        core_req[2] = 1'b0;
        decide();
        wait_done(2, 4);
        issue(2, 1'b0, 12'h123, '0);
        decide();
        wait_done(2, 6);
        check_eq("drop_rd", 32'(last_rd), 32'h05E7);
        decide();

        // Core 0 holds req permanently, core 3 requests once
        observe();
        keep[0] = 1'b1;
        issue(0, 1'b0, 12'h005, '0);
        decide();
        run(4);
        observe();
        done_q.delete(); done_t.delete();
        issue(3, 1'b0, 12'h006, '0);
        rq = cyc;
        decide();
        wait_done(3, 12);
        check_eq("fair_latency", 32'((cyc - rq) <= 5), 32'd1);
        n0 = 0;
        foreach (done_q[i]) if (done_q[i] == 0) n0++;
        check_eq("fair_core0_once", 32'(n0 <= 1), 32'd1);
        keep[0] = 1'b0;
        decide();
        wait_done(0, 12);
        decide();

        // Random traffic with occasional early drops
        for (int n = 0; n < 300; n++) begin
            observe();
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(3) == 0)
                    issue(k, 1'($urandom_range(1)),
                          ($urandom_range(7) == 0) ? 12'hFFF : AW'($urandom_range(15)),
                          W'($urandom));
            end
            if (acc_valid && cyc == acc_cyc + 1 && $urandom_range(3) == 0) core_req[cur] = 1'b0;
            decide();
        end
        run(20);
        for (int k = 0; k < N; k++) check_eq("drain", 32'(pend[k]), 32'd0);

        // Reset in the middle of a write's ACCESS cycle
        observe();
        issue(1, 1'b1, 12'h200, 12'h777);
        decide();
        observe();
        #2 rst = 1'b1;
        #1;
        check_eq("arst_wrEn", 32'(ram_wrEn), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(core_done), 32'd0);
        acc_valid = 1'b0;
        last = N - 1;
        repeat (2) begin
            @(negedge clk);
            cyc++;
            check_eq("rst_hold_busy", 32'(busy), 32'd0);
            check_eq("rst_hold_done", 32'(core_done), 32'd0);
        end
        rst = 1'b0;
        free_at = cyc;
        done_q.delete(); done_t.delete();
        issue(0, 1'b0, 12'h200, '0);
        issue(2, 1'b0, 12'h007, '0);
        issue(3, 1'b0, 12'h008, '0);
        decide();
        run(12);
        check_eq("post_rst_count", 32'(done_q.size()), 32'd4);
        for (int i = 0; i < done_q.size() && i < N; i++)
            check_eq("post_rst_order", 32'(done_q[i]), 32'(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
